// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data RAM between the CPU (absolute priority) and two round-robin secondaries.
// Optional starvation guard built when STARVE_GUARD_EN is defined.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int STARVE_MAX = 15
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            cpu_rd,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic [DW-1:0]   cpu_rdata,
  output logic            cpu_hold,
  input  logic [1:0]      rq_valid,
  input  logic [1:0]      rq_we,
  input  logic [2*AW-1:0] rq_addr,
  input  logic [2*DW-1:0] rq_wdata,
  output logic [1:0]      rq_ready,
  output logic [DW-1:0]   rq_rdata,
  output logic [1:0]      rq_rvalid,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);
  logic cpu_act, grant, win, last_grant, rd_grant;
  logic [AW-1:0] rq_a;
  logic [DW-1:0] rq_d;
  always_comb begin
    cpu_act = (cpu_rd | cpu_we) & ~cpu_hold;
    grant = ~cpu_act & |rq_valid;
    win = &rq_valid ? ~last_grant : rq_valid[1];
    rq_a = win ? rq_addr[AW +: AW] : rq_addr[0 +: AW];
    rq_d = win ? rq_wdata[DW +: DW] : rq_wdata[0 +: DW];
    rd_grant = grant & ~rq_we[win];
    rq_ready = grant ? {win, ~win} : 2'b00;
    mem_addr = grant ? rq_a : cpu_addr;
    mem_wdata = grant ? rq_d : cpu_wdata;
    mem_we = ~RESET & (cpu_act ? cpu_we : grant & rq_we[win]);
    cpu_rdata = mem_rdata;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_grant <= 1'b1;
      rq_rvalid <= 2'b00;
      rq_rdata <= '0;
    end else begin
      if (grant) last_grant <= win;
      rq_rvalid <= rd_grant ? rq_ready : 2'b00;
      if (rd_grant) rq_rdata <= mem_rdata;
    end
  end
`ifdef STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  typedef enum logic {NORM, HOLD} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] starve_cnt, cnt_nxt;
  logic denied;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= NORM;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      starve_cnt <= cnt_nxt;
    end
  end
  // Freeze the CPU on the cycle after the denied cycle that brings the count to STARVE_MAX.
  always_comb begin
    denied = |rq_valid & ~grant;
    cnt_nxt = grant ? '0 : (denied && starve_cnt != CW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
    state_nxt = (state == NORM && denied && cnt_nxt == CW'(STARVE_MAX)) ? HOLD : NORM;
  end
  assign cpu_hold = (state == HOLD);
`else
  assign cpu_hold = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural async-read RAM.
module tb_dmem_arbiter;
  logic CLK = 0, RESET = 0;
  logic cpu_rd = 0, cpu_we = 0;
  logic [7:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
  logic cpu_hold;
  logic [1:0] rq_valid = 0, rq_we = 0, rq_ready, rq_rvalid;
  logic [15:0] rq_addr = 0, rq_wdata = 0;
  logic [7:0] rq_rdata, mem_addr, mem_wdata, mem_rdata;
  logic mem_we;
  logic [7:0] ram [256];
  int checks = 0, failures = 0;

  dmem_arbiter dut (
    .CLK(CLK), .RESET(RESET), .cpu_rd(cpu_rd), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold), .rq_valid(rq_valid),
    .rq_we(rq_we), .rq_addr(rq_addr), .rq_wdata(rq_wdata), .rq_ready(rq_ready),
    .rq_rdata(rq_rdata), .rq_rvalid(rq_rvalid), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs;
    cpu_rd = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    rq_valid = 0; rq_we = 0; rq_addr = 0; rq_wdata = 0;
  endtask

  task automatic apply_reset;
    clear_inputs();
    RESET = 1;
    step();
    RESET = 0;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if (cpu_hold !== 1'b0 || rq_rvalid !== 2'b00 || rq_rdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: hold=%b rvalid=%b rdata=%h, want 0/00/00", cpu_hold, rq_rvalid, rq_rdata);
    end
    cpu_addr = 8'h33;
    #1;
    checks++;
    if (mem_addr !== 8'h33 || mem_we !== 1'b0 || rq_ready !== 2'b00) begin
      failures++;
      $display("FAIL idle: addr=%h we=%b ready=%b, want 33/0/00", mem_addr, mem_we, rq_ready);
    end
  endtask

  task automatic test_cpu_priority;
    cpu_we = 1; cpu_addr = 8'h12; cpu_wdata = 8'hA5;
    rq_valid = 2'b01; rq_we = 2'b00; rq_addr = 16'h0012;
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h12 || mem_wdata !== 8'hA5 || rq_ready !== 2'b00) begin
      failures++;
      $display("FAIL cpu_store: we=%b addr=%h wdata=%h ready=%b, want 1/12/a5/00", mem_we, mem_addr, mem_wdata, rq_ready);
    end
    step();
    cpu_we = 0; cpu_addr = 8'h99;
    #1;
    checks++;
    if (rq_ready !== 2'b01 || mem_addr !== 8'h12 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL deferred_grant: ready=%b addr=%h we=%b, want 01/12/0", rq_ready, mem_addr, mem_we);
    end
    step();
    checks++;
    if (rq_rvalid !== 2'b01 || rq_rdata !== 8'hA5) begin
      failures++;
      $display("FAIL deferred_read: rvalid=%b rdata=%h, want 01/a5", rq_rvalid, rq_rdata);
    end
    rq_valid = 2'b00;
    step();
    checks++;
    if (rq_rvalid !== 2'b00 || rq_rdata !== 8'hA5 || mem_addr !== 8'h99) begin
      failures++;
      $display("FAIL rvalid_clear: rvalid=%b rdata=%h addr=%h, want 00/a5/99", rq_rvalid, rq_rdata, mem_addr);
    end
  endtask

  task automatic test_round_robin;
    cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 8'h11;
    step();
    cpu_addr = 8'h21; cpu_wdata = 8'h22;
    step();
    cpu_we = 0;
    apply_reset();
    rq_valid = 2'b11; rq_we = 2'b00; rq_addr = 16'h2120;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] er;
      logic [7:0] ed;
      er = (k % 2 == 0) ? 2'b01 : 2'b10;
      ed = (k % 2 == 0) ? 8'h11 : 8'h22;
      #1;
      checks++;
      if (rq_ready !== er) begin
        failures++;
        $display("FAIL rr_grant[%0d]: ready=%b, want %b", k, rq_ready, er);
      end
      step();
      checks++;
      if (rq_rvalid !== er || rq_rdata !== ed) begin
        failures++;
        $display("FAIL rr_rvalid[%0d]: rvalid=%b rdata=%h, want %b/%h", k, rq_rvalid, rq_rdata, er, ed);
      end
    end
    rq_valid = 2'b00;
    step();
  endtask

  task automatic test_write_then_load;
    rq_valid = 2'b10; rq_we = 2'b10; rq_addr = 16'h4000; rq_wdata = 16'h3C00;
    #1;
    checks++;
    if (rq_ready !== 2'b10 || mem_we !== 1'b1 || mem_addr !== 8'h40 || mem_wdata !== 8'h3C) begin
      failures++;
      $display("FAIL p1_write: ready=%b we=%b addr=%h wdata=%h, want 10/1/40/3c", rq_ready, mem_we, mem_addr, mem_wdata);
    end
    step();
    rq_valid = 2'b00; rq_we = 2'b00;
    cpu_rd = 1; cpu_addr = 8'h40;
    #1;
    checks++;
    if (cpu_rdata !== 8'h3C || mem_we !== 1'b0 || rq_rvalid !== 2'b00) begin
      failures++;
      $display("FAIL cpu_load: rdata=%h we=%b rvalid=%b, want 3c/0/00", cpu_rdata, mem_we, rq_rvalid);
    end
    step();
    cpu_rd = 0;
  endtask

  task automatic test_reset_write;
    cpu_we = 1; cpu_addr = 8'h55; cpu_wdata = 8'h77;
    step();
    cpu_we = 0;
    rq_valid = 2'b01; rq_we = 2'b01; rq_addr = 16'h0055; rq_wdata = 16'h0099;
    RESET = 1;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_write_we: we=%b, want 0", mem_we);
    end
    step();
    RESET = 0;
    checks++;
    if (cpu_hold !== 1'b0 || rq_rvalid !== 2'b00 || rq_rdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: hold=%b rvalid=%b rdata=%h, want 0/00/00", cpu_hold, rq_rvalid, rq_rdata);
    end
    rq_valid = 2'b00; rq_we = 2'b00;
    cpu_rd = 1; cpu_addr = 8'h55;
    #1;
    checks++;
    if (cpu_rdata !== 8'h77) begin
      failures++;
      $display("FAIL reset_write_lost: ram=%h, want 77", cpu_rdata);
    end
    step();
    cpu_rd = 0;
  endtask

`ifdef STARVE_GUARD_EN
  task automatic test_starve;
    cpu_rd = 1; cpu_addr = 8'h00;
    rq_valid = 2'b10; rq_we = 2'b00; rq_addr = 16'h4000;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 15; i++) begin
        #1;
        checks++;
        if (cpu_hold !== 1'b0 || rq_ready !== 2'b00) begin
          failures++;
          $display("FAIL starve_denied[%0d.%0d]: hold=%b ready=%b, want 0/00", r, i, cpu_hold, rq_ready);
        end
        step();
      end
      #1;
      checks++;
      if (cpu_hold !== 1'b1 || rq_ready !== 2'b10 || mem_addr !== 8'h40) begin
        failures++;
        $display("FAIL starve_hold[%0d]: hold=%b ready=%b addr=%h, want 1/10/40", r, cpu_hold, rq_ready, mem_addr);
      end
      step();
      checks++;
      if (cpu_hold !== 1'b0 || rq_rvalid !== 2'b10 || rq_rdata !== 8'h3C) begin
        failures++;
        $display("FAIL starve_release[%0d]: hold=%b rvalid=%b rdata=%h, want 0/10/3c", r, cpu_hold, rq_rvalid, rq_rdata);
      end
    end
    clear_inputs();
    step();
  endtask
`else
  task automatic test_starve;
    cpu_rd = 1; cpu_addr = 8'h00;
    rq_valid = 2'b10; rq_we = 2'b00; rq_addr = 16'h4000;
    for (int i = 0; i < 100; i++) begin
      #1;
      checks++;
      if (cpu_hold !== 1'b0 || rq_ready !== 2'b00) begin
        failures++;
        $display("FAIL no_guard[%0d]: hold=%b ready=%b, want 0/00", i, cpu_hold, rq_ready);
      end
      step();
    end
    clear_inputs();
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_priority();
    test_round_robin();
    test_write_then_load();
    test_reset_write();
    test_starve();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
